// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage controller and the multi-cycle divider.
// The controller drives the request side; the divider drives the result side.
interface div_unit_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  F;
  logic [31:0] Y;
  logic        busy;
  logic        done;

  modport master (output start, A, B, F, input Y, busy, done);
  modport slave  (input start, A, B, F, output Y, busy, done);
endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider using a radix-2 restoring iteration.
// Every request takes a fixed 33 cycles from accept to done, including divide-by-zero.
module div_unit (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e      state_q, state_d;
  logic        is_rem_q, is_rem_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        bz_q, bz_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] y_q, y_d;

  logic        is_signed;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic [31:0] step_quo;
  logic [32:0] step_rem;
  logic [31:0] result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      is_rem_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      is_rem_q <= is_rem_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
    end
  end

  // One restoring step; the 34-bit trial keeps the borrow visible for divisors >= 2^31.
  always_comb begin
    shifted  = {rem_q[31:0], quo_q[31]};
    trial    = {1'b0, shifted} - {2'b00, dvs_q};
    if (!trial[33]) begin
      step_rem = trial[32:0];
      step_quo = {quo_q[30:0], 1'b1};
    end else begin
      step_rem = shifted;
      step_quo = {quo_q[30:0], 1'b0};
    end
  end

  // Divide-by-zero quotient is forced to all ones regardless of operand signs.
  always_comb begin
    if (!is_rem_q) begin
      if (bz_q)             result = '1;
      else if (sa_q ^ sb_q) result = -step_quo;
      else                  result = step_quo;
    end else begin
      result = sa_q ? -step_rem[31:0] : step_rem[31:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    bz_d      = bz_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    is_signed = ~bus.F[0];

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          is_rem_d = bus.F[1];
          sa_d     = is_signed & bus.A[31];
          sb_d     = is_signed & bus.B[31];
          bz_d     = (bus.B == 32'd0);
          quo_d    = (is_signed & bus.A[31]) ? -bus.A : bus.A;
          dvs_d    = (is_signed & bus.B[31]) ? -bus.B : bus.B;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          y_d     = result;
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.Y    = y_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StFin);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops scored against
// a plain-arithmetic reference, with latency, busy/done and reset-abort checks.
module tb_div_unit;

  logic clk = 1'b0;
  logic reset;

  div_unit_if bus ();

  div_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V style M-extension division semantics from plain arithmetic.
  function automatic logic [31:0] model_div(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Starts at a negedge in IDLE; returns at the negedge where done is seen (or timeout).
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output logic [31:0] y, output int lat);
    bus.start = 1'b1;
    bus.F     = f;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.F     = 2'($urandom);
    lat = 0;
    while (lat < 40) begin
      bus.start = (poke && lat == 5);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) break;
    end
    bus.start = 1'b0;
    y = bus.Y;
  endtask

  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
    string       t;
    exp = model_div(f, a, b);
    t   = $sformatf("op%0d a=%h b=%h", f, a, b);
    run_op(f, a, b, poke, y, lat);
    check({t, " Y"}, y, exp);
    // done is visible after the 32nd edge following the accept edge (33rd cycle).
    check({t, " latency"}, 32'(lat), 32'd32);
    check({t, " busy_at_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({t, " done_cleared"}, 32'(bus.done), 32'd0);
    check({t, " busy_cleared"}, 32'(bus.busy), 32'd0);
    check({t, " Y_held"}, bus.Y, exp);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  initial begin
    int          n;
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.F     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset Y", bus.Y, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);

    // Each do_op starts in the first IDLE cycle after the previous one: back-to-back issue.
    do_op(2'b01, 32'd100, 32'd7, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 1'b0);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(2'b00, 32'd5, 32'd0, 1'b0);
    do_op(2'b10, 32'd5, 32'd0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFB, 32'd0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

    // start pulsed mid-calculation must be ignored and never produce a second done.
    do_op(2'b01, 32'd100, 32'd7, 1'b1);
    count_dones(40, n);
    check("ignored start extra done", 32'(n), 32'd0);
    check("ignored start busy", 32'(bus.busy), 32'd0);

    // Abort 10 cycles after accept.
    bus.start = 1'b1;
    bus.F     = 2'b01;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort Y", bus.Y, 32'd0);
    count_dones(40, n);
    check("abort no done", 32'(n), 32'd0);
    do_op(2'b00, 32'hFFFF_FC18, 32'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      f = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      do_op(f, a, b, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
